// File: rtl/inst_fetch_req_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch request controller.
// Holds the state encoding, address type and fetch-group arithmetic.
package inst_fetch_req_ctrl_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t RESET_PC_DEFAULT  = 32'hBFC0_0000;
  localparam addr_t FETCH_GROUP_BYTES = 32'd16;
  localparam logic  TRUE              = 1'b1;
  localparam logic  FALSE             = 1'b0;

  typedef enum logic [1:0] {
    StRunWait = 2'd0,
    StReqHold = 2'd1,
    StDrain   = 2'd2
  } fetch_state_e;

  // Start of the next aligned fetch group; a redirect target's low bits are discarded here.
  function automatic addr_t next_group_pc(addr_t pc);
    return {pc[31:4], 4'b0000} + FETCH_GROUP_BYTES;
  endfunction

endpackage

// File: rtl/inst_fetch_req_ctrl_if.sv
// ICache request/response handshake between the fetch controller (master) and the cache (slave).
interface inst_fetch_req_ctrl_if;
  import inst_fetch_req_ctrl_pkg::*;

  logic  inst_req_o;
  addr_t inst_addr_o;
  logic  inst_addr_ok_i;
  logic  inst_data_ok_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_addr_ok_i,
    input  inst_data_ok_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_addr_ok_i,
    output inst_data_ok_i
  );

endinterface

// File: rtl/inst_fetch_req_ctrl_outst_counter.sv
// Outstanding-request and stale-response counters for the fetch controller.
// The drop count marks how many of the in-flight responses belong to a pre-redirect stream.
module inst_fetch_req_ctrl_outst_counter #(
  parameter int unsigned MaxOutst = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_i,
  input  logic       data_ok_i,
  input  logic       load_drop_i,
  input  logic       add_drop_i,
  output logic [1:0] outst_o,
  output logic [1:0] outst_next_o,
  output logic [1:0] drop_o,
  output logic       resp_drop_o
);

  localparam logic [1:0] MaxCnt = 2'(MaxOutst);

  logic [1:0] outst_q, outst_d;
  logic [1:0] drop_q, drop_d;
  logic       stale;

  always_comb begin
    stale   = data_ok_i && (drop_q != 2'd0);
    outst_d = outst_q + {1'b0, fire_i} - {1'b0, data_ok_i};
    drop_d  = drop_q;
    // A fresh redirect makes everything still in flight stale, including a same-cycle fire.
    if (load_drop_i) begin
      drop_d = outst_d;
    end else begin
      drop_d = drop_q + {1'b0, add_drop_i} - {1'b0, stale};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= 2'd0;
      drop_q  <= 2'd0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  assign outst_o      = outst_q;
  assign outst_next_o = outst_d;
  assign drop_o       = drop_q;
  assign resp_drop_o  = stale;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    data_ok_i |-> (outst_q != 2'd0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fire_i && !data_ok_i && (outst_q == MaxCnt)));
  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop_q <= outst_q);

endmodule

// File: rtl/inst_fetch_req_ctrl.sv
// IF-stage ICache request sequencer: owns the fetch PC, issues 16B group requests and flags
// responses of requests made before a redirect so later stages can drop them.
module inst_fetch_req_ctrl
  import inst_fetch_req_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter addr_t       RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_w_i,
  input  addr_t                 redirect_pc_i,
  input  logic                  pred_take_i,
  input  addr_t                 pred_dest_i,
  input  logic                  down_allowin_i,
  inst_fetch_req_ctrl_if.master bus,
  output logic                  req_fire_o,
  output logic                  resp_drop_o,
  output logic [1:0]            outst_cnt_o
);

  localparam logic [1:0] MaxCnt = 2'(MAX_OUTST);

  fetch_state_e state_q;
  addr_t        pc_q, pc_next;
  addr_t        addr_q;
  logic         req_q;
  logic         fire;
  logic         can_issue;
  logic [1:0]   outst, outst_next, drop;

  assign fire = req_q && bus.inst_addr_ok_i;

  inst_fetch_req_ctrl_outst_counter #(
    .MaxOutst (MAX_OUTST)
  ) u_outst_counter (
    .clk          (clk),
    .rst          (rst),
    .fire_i       (fire),
    .data_ok_i    (bus.inst_data_ok_i),
    .load_drop_i  (redirect_w_i && (state_q != StDrain)),
    .add_drop_i   (fire && (state_q == StDrain)),
    .outst_o      (outst),
    .outst_next_o (outst_next),
    .drop_o       (drop),
    .resp_drop_o  (resp_drop_o)
  );

  always_comb begin
    pc_next = pc_q;
    // A stale request firing while draining must not clobber the redirect target.
    if (redirect_w_i) begin
      pc_next = redirect_pc_i;
    end else if (fire && (state_q != StDrain)) begin
      pc_next = pred_take_i ? pred_dest_i : next_group_pc(pc_q);
    end
    can_issue = down_allowin_i && (outst_next < MaxCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRunWait;
      pc_q    <= RESET_PC;
      req_q   <= FALSE;
      addr_q  <= RESET_PC;
    end else begin
      pc_q <= pc_next;
      unique case (state_q)
        StRunWait: begin
          if (redirect_w_i) begin
            state_q <= (outst_next == 2'd0) ? StRunWait : StDrain;
          end else if (can_issue) begin
            req_q   <= TRUE;
            addr_q  <= pc_q;
            state_q <= StReqHold;
          end
        end
        StReqHold: begin
          if (redirect_w_i) begin
            // Either the held request or the one firing now is stale, so draining is certain.
            req_q   <= !fire;
            state_q <= StDrain;
          end else if (fire) begin
            if (can_issue) begin
              addr_q <= pc_next;
            end else begin
              req_q   <= FALSE;
              state_q <= StRunWait;
            end
          end
        end
        StDrain: begin
          if (fire) begin
            req_q <= FALSE;
          end
          if ((drop == 2'd0) && !req_q) begin
            state_q <= StRunWait;
          end
        end
        default: state_q <= StRunWait;
      endcase
    end
  end

  assign bus.inst_req_o  = req_q;
  assign bus.inst_addr_o = addr_q;
  assign req_fire_o      = fire;
  assign outst_cnt_o     = outst;

endmodule

// File: tb/tb_inst_fetch_req_ctrl.sv
// Bench for inst_fetch_req_ctrl: an in-order ICache model with an epoch-tagged response
// scoreboard, a table of fetch vectors, and hand-written redirect/reset sequences.
module tb_inst_fetch_req_ctrl;
  import inst_fetch_req_ctrl_pkg::*;

  typedef struct {
    logic        take;
    logic [31:0] dest;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_w_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        pred_take_i = 1'b0;
  logic [31:0] pred_dest_i = 32'd0;
  logic        down_allowin_i = 1'b0;
  logic        req_fire_o;
  logic        resp_drop_o;
  logic [1:0]  outst_cnt_o;

  inst_fetch_req_ctrl_if bus();

  inst_fetch_req_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_w_i   (redirect_w_i),
    .redirect_pc_i  (redirect_pc_i),
    .pred_take_i    (pred_take_i),
    .pred_dest_i    (pred_dest_i),
    .down_allowin_i (down_allowin_i),
    .bus            (bus),
    .req_fire_o     (req_fire_o),
    .resp_drop_o    (resp_drop_o),
    .outst_cnt_o    (outst_cnt_o)
  );

  always #5 clk = ~clk;

  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] exp_q[$];
  int unsigned resp_q[$];
  int unsigned epoch = 0;
  bit          held_stale = 1'b0;
  int unsigned held_tag = 0;
  bit          dok_en = 1'b0;
  bit          fired = 1'b0;
  int          drops_seen = 0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive cache response, sample at negedge, update model, return at posedge+1.
  task automatic cycle();
    int unsigned cur;
    int unsigned tag;
    bit          f;
    bus.inst_data_ok_i = dok_en && (resp_q.size() != 0);
    @(negedge clk);
    cur   = epoch;
    fired = 1'b0;
    chk("outst_cnt", 32'(outst_cnt_o), 32'(resp_q.size()));
    f = bus.inst_req_o && bus.inst_addr_ok_i;
    chk("req_fire", 32'(req_fire_o), 32'(f));
    if (bus.inst_data_ok_i) begin
      tag = resp_q.pop_front();
      chk("resp_drop", 32'(resp_drop_o), 32'(tag != cur));
      if (resp_drop_o) drops_seen++;
    end else begin
      chk("drop_idle", 32'(resp_drop_o), 32'd0);
    end
    if (f) begin
      fired = 1'b1;
      if (exp_q.size() != 0) chk("fetch_addr", bus.inst_addr_o, exp_q.pop_front());
      if (held_stale) begin
        tag        = held_tag;
        held_stale = 1'b0;
      end else begin
        tag = cur;
      end
      resp_q.push_back(tag);
    end
    if (redirect_w_i && !rst) begin
      if (bus.inst_req_o && !f && !held_stale) begin
        held_stale = 1'b1;
        held_tag   = cur;
      end
      epoch++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fire(input int budget);
    int n = 0;
    fired = 1'b0;
    while (!fired && n < budget) begin
      cycle();
      n++;
    end
    chk("fire_timeout", 32'(fired), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'h0,         32'hBFC0_0000};
    vecs[1] = '{1'b1, 32'h8000_1234, 32'hBFC0_0010};
    vecs[2] = '{1'b0, 32'h0,         32'h8000_1234};
    vecs[3] = '{1'b0, 32'h0,         32'h8000_1240};
    vecs[4] = '{1'b1, 32'h9000_0104, 32'h8000_1250};
    vecs[5] = '{1'b0, 32'h0,         32'h9000_0104};
    vecs[6] = '{1'b0, 32'h0,         32'h9000_0110};
    vecs[7] = '{1'b0, 32'h0,         32'h9000_0120};

    bus.inst_addr_ok_i = 1'b0;
    bus.inst_data_ok_i = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;
    chk("rst_req", 32'(bus.inst_req_o), 32'd0);
    chk("rst_addr", bus.inst_addr_o, 32'hBFC0_0000);
    chk("rst_outst", 32'(outst_cnt_o), 32'd0);
    chk("rst_drop", 32'(resp_drop_o), 32'd0);
    idle(1);

    // Sequential fetch and predicted-taken redirects of the next group.
    down_allowin_i     = 1'b1;
    bus.inst_addr_ok_i = 1'b1;
    dok_en             = 1'b1;
    drops_seen         = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_addr);
      pred_take_i = vecs[i].take;
      pred_dest_i = vecs[i].dest;
      wait_fire(6);
    end
    pred_take_i    = 1'b0;
    down_allowin_i = 1'b0;
    idle(4);
    chk("t1_drops", 32'(drops_seen), 32'd0);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);

    // addr_ok stalled: request and address must hold steady.
    bus.inst_addr_ok_i = 1'b0;
    down_allowin_i     = 1'b1;
    n = 0;
    while (!bus.inst_req_o && n < 5) begin
      cycle();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_req", 32'(bus.inst_req_o), 32'd1);
      chk("hold_addr", bus.inst_addr_o, 32'h9000_0140);
      cycle();
    end
    exp_q.push_back(32'h9000_0140);
    bus.inst_addr_ok_i = 1'b1;
    down_allowin_i     = 1'b0;
    wait_fire(3);
    idle(3);

    // Two outstanding, then redirect: both responses dropped before the new fetch.
    dok_en         = 1'b0;
    down_allowin_i = 1'b1;
    exp_q.push_back(32'h9000_0150);
    exp_q.push_back(32'h9000_0160);
    n = 0;
    while (!(outst_cnt_o == 2'd2 && !bus.inst_req_o) && n < 8) begin
      cycle();
      n++;
    end
    chk("t4_fill", 32'(outst_cnt_o), 32'd2);
    redirect_w_i   = 1'b1;
    redirect_pc_i  = 32'h9FC0_0100;
    down_allowin_i = 1'b0;
    cycle();
    redirect_w_i   = 1'b0;
    drops_seen     = 0;
    dok_en         = 1'b1;
    down_allowin_i = 1'b1;
    exp_q.push_back(32'h9FC0_0100);
    wait_fire(10);
    down_allowin_i = 1'b0;
    idle(4);
    chk("t4_drops", 32'(drops_seen), 32'd2);
    chk("t4_queue", 32'(exp_q.size()), 32'd0);

    // Redirect coinciding with a fire and a live response, one outstanding.
    down_allowin_i = 1'b1;
    n = 0;
    while (!(bus.inst_req_o && resp_q.size() == 1) && n < 8) begin
      cycle();
      n++;
    end
    chk("t5_setup", 32'(resp_q.size()), 32'd1);
    redirect_w_i  = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    drops_seen    = 0;
    cycle();
    redirect_w_i = 1'b0;
    exp_q.push_back(32'h0000_2000);
    wait_fire(10);
    down_allowin_i = 1'b0;
    idle(4);
    chk("t5_drops", 32'(drops_seen), 32'd1);
    chk("t5_queue", 32'(exp_q.size()), 32'd0);

    // Reset while draining: everything clears and fetch restarts at the reset PC.
    dok_en         = 1'b0;
    down_allowin_i = 1'b1;
    n = 0;
    while (!(outst_cnt_o == 2'd2 && !bus.inst_req_o) && n < 8) begin
      cycle();
      n++;
    end
    redirect_w_i   = 1'b1;
    redirect_pc_i  = 32'h1234_5670;
    down_allowin_i = 1'b0;
    cycle();
    redirect_w_i = 1'b0;
    cycle();
    rst                = 1'b1;
    bus.inst_addr_ok_i = 1'b0;
    cycle();
    rst = 1'b0;
    resp_q.delete();
    exp_q.delete();
    held_stale = 1'b0;
    chk("rst2_req", 32'(bus.inst_req_o), 32'd0);
    chk("rst2_addr", bus.inst_addr_o, 32'hBFC0_0000);
    chk("rst2_outst", 32'(outst_cnt_o), 32'd0);
    chk("rst2_drop", 32'(resp_drop_o), 32'd0);
    dok_en             = 1'b1;
    down_allowin_i     = 1'b1;
    bus.inst_addr_ok_i = 1'b1;
    drops_seen         = 0;
    exp_q.push_back(32'hBFC0_0000);
    wait_fire(6);
    down_allowin_i = 1'b0;
    idle(4);
    chk("t6_drops", 32'(drops_seen), 32'd0);
    chk("t6_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
